// File: rtl/motor_cmd_ramp_pkg.sv
// Shared types and slew arithmetic for the wheel speed command ramp.
// Speeds are SPEED_W+1-bit two's complement; commands are magnitude plus a reverse flag.
package motor_cmd_ramp_pkg;

    localparam int SPEED_W = 8;

    typedef logic signed [SPEED_W:0]   speed_t;
    typedef logic signed [SPEED_W+1:0] wide_t;

    typedef struct packed {
        logic [SPEED_W-1:0] mag;
        logic               neg;
    } wheel_cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ramp_state_t;

    localparam speed_t SPEED_MIN = {1'b1, {SPEED_W{1'b0}}};

    // One slew update: move toward tgt by at most step; a sign change lands on zero first.
    function automatic speed_t slew_step(speed_t cur, speed_t tgt, int step);
        wide_t c;
        wide_t t;
        wide_t s;
        wide_t d;
        wide_t n;
        c = wide_t'(cur);
        t = wide_t'(tgt);
        if (tgt == SPEED_MIN) begin
            t = t + wide_t'(1);
        end
        s = wide_t'(step);
        d = t - c;
        if (d > s) begin
            d = s;
        end else if (d < -s) begin
            d = -s;
        end
        n = c + d;
        if ((c != '0) && (n != '0) && (c[SPEED_W+1] != n[SPEED_W+1])) begin
            n = '0;
        end
        return speed_t'(n);
    endfunction

    function automatic wheel_cmd_t encode(speed_t v);
        wheel_cmd_t r;
        speed_t     a;
        a     = v[SPEED_W] ? -v : v;
        r.mag = a[SPEED_W-1:0];
        r.neg = v[SPEED_W];
        return r;
    endfunction

endpackage

// File: rtl/motor_cmd_ramp_if.sv
// Valid/ready command channel carrying both wheel commands toward uart_comm.
interface motor_cmd_ramp_if import motor_cmd_ramp_pkg::*;;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [SPEED_W-1:0] mag_l;
    logic [SPEED_W-1:0] mag_r;
    logic               neg_l;
    logic               neg_r;

    modport master (
        output cmd_valid,
        output mag_l,
        output mag_r,
        output neg_l,
        output neg_r,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  mag_l,
        input  mag_r,
        input  neg_l,
        input  neg_r,
        output cmd_ready
    );

endinterface

// File: rtl/motor_cmd_ramp_rate_tick.sv
// Free-running divider producing a single-cycle pulse every DIV clocks.
// The pulse sits on the last count, so the first one arrives DIV cycles after reset.
module motor_cmd_ramp_rate_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/motor_cmd_ramp.sv
// Turns signed wheel targets into slew-limited magnitude/direction commands at a fixed rate,
// with an emergency-stop path that zeroes both wheels.
module motor_cmd_ramp import motor_cmd_ramp_pkg::*; #(
    parameter int SPEED_W   = 8,
    parameter int CLK_HZ    = 50_000_000,
    parameter int UPDATE_HZ = 50,
    parameter int STEP      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SPEED_W:0]  i_tgt_l,
    input  logic signed [SPEED_W:0]  i_tgt_r,
    input  logic                     i_estop,
    output logic                     o_overrun,
    motor_cmd_ramp_if.master         cmd_if
);

    localparam int TICK_DIV = CLK_HZ / UPDATE_HZ;

    if ((SPEED_W != motor_cmd_ramp_pkg::SPEED_W) || (TICK_DIV < 2) || (STEP < 1)) begin : g_bad_param
        $error("motor_cmd_ramp: unsupported parameter set");
    end

    logic        w_tick;
    logic        w_hs;
    logic        w_zero_req;
    logic        w_load;
    ramp_state_t r_state, w_state_nxt;
    speed_t      r_cur_l, r_cur_r, w_cur_l_nxt, w_cur_r_nxt;
    speed_t      w_slew_l, w_slew_r, w_next_l, w_next_r;
    wheel_cmd_t  r_cmd_l, r_cmd_r, w_cmd_l_nxt, w_cmd_r_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_overrun, w_overrun_nxt;
    logic        r_zero_pend, w_zero_pend_nxt;
    logic        r_estop_d;

    motor_cmd_ramp_rate_tick #(.DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    assign w_slew_l   = slew_step(r_cur_l, i_tgt_l, STEP);
    assign w_slew_r   = slew_step(r_cur_r, i_tgt_r, STEP);
    assign w_hs       = r_valid && cmd_if.cmd_ready;
    // A fresh estop edge, or one that arrived while a command was still pending.
    assign w_zero_req = r_zero_pend || (i_estop && !r_estop_d);
    assign w_next_l   = (w_zero_req || i_estop) ? '0 : w_slew_l;
    assign w_next_r   = (w_zero_req || i_estop) ? '0 : w_slew_r;

    always_comb begin
        w_state_nxt     = r_state;
        w_cur_l_nxt     = r_cur_l;
        w_cur_r_nxt     = r_cur_r;
        w_cmd_l_nxt     = r_cmd_l;
        w_cmd_r_nxt     = r_cmd_r;
        w_valid_nxt     = r_valid;
        w_overrun_nxt   = r_overrun;
        w_zero_pend_nxt = r_zero_pend;
        w_load          = 1'b0;

        case (r_state)
            IDLE: begin
                w_load = w_tick || w_zero_req;
            end
            SEND: begin
                if (w_hs) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
                    w_load      = w_tick || w_zero_req;
                end else begin
                    // Outputs stay frozen; a tick here is lost and flagged.
                    if (w_tick) begin
                        w_overrun_nxt = 1'b1;
                    end
                    if (w_zero_req) begin
                        w_zero_pend_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_load) begin
            w_cur_l_nxt     = w_next_l;
            w_cur_r_nxt     = w_next_r;
            w_cmd_l_nxt     = encode(w_next_l);
            w_cmd_r_nxt     = encode(w_next_r);
            w_valid_nxt     = 1'b1;
            w_state_nxt     = SEND;
            w_zero_pend_nxt = 1'b0;
        end

        if (i_estop) begin
            w_cur_l_nxt = '0;
            w_cur_r_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cur_l     <= '0;
            r_cur_r     <= '0;
            r_cmd_l     <= '0;
            r_cmd_r     <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_zero_pend <= 1'b0;
            r_estop_d   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_l     <= w_cur_l_nxt;
            r_cur_r     <= w_cur_r_nxt;
            r_cmd_l     <= w_cmd_l_nxt;
            r_cmd_r     <= w_cmd_r_nxt;
            r_valid     <= w_valid_nxt;
            r_overrun   <= w_overrun_nxt;
            r_zero_pend <= w_zero_pend_nxt;
            r_estop_d   <= i_estop;
        end
    end

    assign cmd_if.cmd_valid = r_valid;
    assign cmd_if.mag_l     = r_cmd_l.mag;
    assign cmd_if.neg_l     = r_cmd_l.neg;
    assign cmd_if.mag_r     = r_cmd_r.mag;
    assign cmd_if.neg_r     = r_cmd_r.neg;
    assign o_overrun        = r_overrun;

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Bench for motor_cmd_ramp: directed scenarios plus a randomized run, all checked every cycle
// against an integer reference model of the ramp, handshake and estop rules.
module tb_motor_cmd_ramp;

    localparam int CLK_HZ    = 1000;
    localparam int UPDATE_HZ = 100;
    localparam int DIV       = CLK_HZ / UPDATE_HZ;
    localparam int STEP      = 4;
    localparam int MAXM      = 255;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic signed [8:0] tgt_l = '0;
    logic signed [8:0] tgt_r = '0;
    logic              estop = 1'b0;
    logic              overrun;

    motor_cmd_ramp_if cmd_if();

    motor_cmd_ramp #(
        .SPEED_W   (8),
        .CLK_HZ    (CLK_HZ),
        .UPDATE_HZ (UPDATE_HZ),
        .STEP      (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_tgt_l   (tgt_l),
        .i_tgt_r   (tgt_r),
        .i_estop   (estop),
        .o_overrun (overrun),
        .cmd_if    (cmd_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int log_l[$];
    int log_r[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Command as seen on the wire: {neg, mag} packed into one number.
    function automatic int enc(int v);
        return (v < 0) ? 256 - v : v;
    endfunction

    // Speed after one update, straight from the slew and zero-crossing rules.
    function automatic int m_slew(int cur, int tgt);
        int t;
        int n;
        t = (tgt < -MAXM) ? -MAXM : tgt;
        n = t;
        if (t > cur + STEP) n = cur + STEP;
        if (t < cur - STEP) n = cur - STEP;
        if (cur * n < 0) n = 0;
        return n;
    endfunction

    // Reference model, advanced once per clock from the inputs that clock sees.
    int m_cycles, m_cur_l, m_cur_r, m_out_l, m_out_r;
    bit m_valid, m_overrun, m_pend, m_estop_seen;
    bit e_tick, e_taken, e_stop_edge, e_slot_free, e_want_zero;

    always @(posedge clk) begin
        if (rst) begin
            m_cycles = 0; m_cur_l = 0; m_cur_r = 0; m_out_l = 0; m_out_r = 0;
            m_valid = 0; m_overrun = 0; m_pend = 0; m_estop_seen = 0;
        end else begin
            m_cycles++;
            e_tick       = (m_cycles % DIV) == 0;
            e_taken      = m_valid && cmd_if.cmd_ready;
            e_stop_edge  = estop && !m_estop_seen;
            m_estop_seen = estop;
            e_slot_free  = !m_valid || e_taken;
            e_want_zero  = m_pend || e_stop_edge;
            if (e_taken) m_valid = 0;
            if (e_slot_free && (e_tick || e_want_zero)) begin
                if (e_want_zero || estop) begin
                    m_cur_l = 0;
                    m_cur_r = 0;
                end else begin
                    m_cur_l = m_slew(m_cur_l, int'(tgt_l));
                    m_cur_r = m_slew(m_cur_r, int'(tgt_r));
                end
                m_out_l = enc(m_cur_l);
                m_out_r = enc(m_cur_r);
                m_valid = 1;
                m_pend  = 0;
            end else begin
                if (e_want_zero) m_pend = 1;
                if (!e_slot_free && e_tick) m_overrun = 1;
            end
            if (estop) begin
                m_cur_l = 0;
                m_cur_r = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cmd_valid", 32'(cmd_if.cmd_valid), 32'(m_valid));
            chk("overrun", 32'(overrun), 32'(m_overrun));
            if (m_valid) begin
                chk("cmd_l", 32'({cmd_if.neg_l, cmd_if.mag_l}), 32'(m_out_l));
                chk("cmd_r", 32'({cmd_if.neg_r, cmd_if.mag_r}), 32'(m_out_r));
            end
            if (cmd_if.cmd_valid === 1'b1 && cmd_if.cmd_ready === 1'b1) begin
                log_l.push_back(int'({cmd_if.neg_l, cmd_if.mag_l}));
                log_r.push_back(int'({cmd_if.neg_r, cmd_if.mag_r}));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_l.delete();
        log_r.delete();
    endtask

    task automatic wait_log(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (log_l.size() < n && k < budget) begin
            cyc(1);
            k++;
        end
        chk(nm, 32'(log_l.size() >= n), 32'd1);
    endtask

    function automatic int at_l(input int i);
        return (i < log_l.size()) ? log_l[i] : -1;
    endfunction

    function automatic int at_r(input int i);
        return (i < log_r.size()) ? log_r[i] : -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int viol;
        logic [8:0] rnd;

        // Reset state and first ramp.
        cmd_if.cmd_ready = 1'b1;
        rst = 1'b1;
        cyc(3);
        chk("rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
        chk("rst_mag_l", 32'(cmd_if.mag_l), 32'd0);
        chk("rst_mag_r", 32'(cmd_if.mag_r), 32'd0);
        chk("rst_neg", 32'({cmd_if.neg_l, cmd_if.neg_r}), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        clear_log();
        tgt_l = 9'sd10;
        rst   = 1'b0;
        k = 0;
        while (cmd_if.cmd_valid !== 1'b1 && k < 30) begin
            cyc(1);
            k++;
        end
        chk("first_valid_edges", 32'(k), 32'd10);
        wait_log(4, 60, "ramp_up_done");
        chk("ramp_up_0", 32'(at_l(0)), 32'(enc(4)));
        chk("ramp_up_1", 32'(at_l(1)), 32'(enc(8)));
        chk("ramp_up_2", 32'(at_l(2)), 32'(enc(10)));
        chk("ramp_up_3", 32'(at_l(3)), 32'(enc(10)));

        // Reversal from +6 to -7 passes through an explicit zero command.
        clear_log();
        tgt_l = 9'sd6;
        wait_log(1, 30, "to_six_done");
        chk("to_six", 32'(at_l(0)), 32'(enc(6)));
        clear_log();
        tgt_l = -9'sd7;
        wait_log(4, 60, "reverse_done");
        chk("reverse_0", 32'(at_l(0)), 32'(enc(2)));
        chk("reverse_1", 32'(at_l(1)), 32'(enc(0)));
        chk("reverse_2", 32'(at_l(2)), 32'(enc(-4)));
        chk("reverse_3", 32'(at_l(3)), 32'(enc(-7)));

        // Downstream stall across two ticks.
        clear_log();
        tgt_l = -9'sd20;
        cmd_if.cmd_ready = 1'b0;
        k = 0;
        while (cmd_if.cmd_valid !== 1'b1 && k < 30) begin
            cyc(1);
            k++;
        end
        chk("stall_valid_seen", 32'(cmd_if.cmd_valid), 32'd1);
        cyc(25);
        chk("stall_overrun", 32'(overrun), 32'd1);
        chk("stall_held_l", 32'({cmd_if.neg_l, cmd_if.mag_l}), 32'(enc(-11)));
        cmd_if.cmd_ready = 1'b1;
        wait_log(2, 40, "stall_release_done");
        chk("stall_first", 32'(at_l(0)), 32'(enc(-11)));
        chk("stall_advance_once", 32'(at_l(1)), 32'(enc(-15)));

        // Emergency stop from IDLE with the right wheel at 20.
        tgt_l = -9'sd15;
        tgt_r = 9'sd20;
        clear_log();
        wait_log(5, 80, "right_ramp_done");
        chk("right_at_20", 32'(at_r(4)), 32'(enc(20)));
        clear_log();
        estop = 1'b1;
        cyc(1);
        estop = 1'b0;
        chk("estop_valid", 32'(cmd_if.cmd_valid), 32'd1);
        chk("estop_cmd_r", 32'({cmd_if.neg_r, cmd_if.mag_r}), 32'd0);
        chk("estop_cmd_l", 32'({cmd_if.neg_l, cmd_if.mag_l}), 32'd0);
        wait_log(3, 40, "estop_resume_done");
        chk("resume_r0", 32'(at_r(0)), 32'(enc(0)));
        chk("resume_r1", 32'(at_r(1)), 32'(enc(4)));
        chk("resume_r2", 32'(at_r(2)), 32'(enc(8)));
        chk("resume_l1", 32'(at_l(1)), 32'(enc(-4)));

        // Most negative target saturates at -255 without wrapping (from -8).
        clear_log();
        tgt_l = -9'sd256;
        tgt_r = 9'sd0;
        wait_log(70, 900, "saturate_done");
        chk("sat_60", 32'(at_l(60)), 32'(enc(-252)));
        chk("sat_61", 32'(at_l(61)), 32'(enc(-255)));
        chk("sat_69", 32'(at_l(69)), 32'(enc(-255)));
        viol = 0;
        for (int i = 1; i < log_l.size(); i++) begin
            if (log_l[i] < log_l[i-1]) viol++;
        end
        chk("sat_monotone", 32'(viol), 32'd0);

        // Handshake on the same clock as a tick.
        rst = 1'b1;
        tgt_l = 9'sd10;
        tgt_r = 9'sd0;
        cmd_if.cmd_ready = 1'b0;
        cyc(2);
        clear_log();
        rst = 1'b0;
        cyc(19);
        chk("coinc_pending", 32'(cmd_if.cmd_valid), 32'd1);
        cmd_if.cmd_ready = 1'b1;
        cyc(1);
        chk("coinc_valid_held", 32'(cmd_if.cmd_valid), 32'd1);
        chk("coinc_next_cmd", 32'({cmd_if.neg_l, cmd_if.mag_l}), 32'(enc(8)));
        chk("coinc_overrun", 32'(overrun), 32'd0);
        cyc(1);
        chk("coinc_log0", 32'(at_l(0)), 32'(enc(4)));
        chk("coinc_log1", 32'(at_l(1)), 32'(enc(8)));

        // Randomized targets, backpressure and estop pulses.
        for (int c = 0; c < 3000; c++) begin
            cmd_if.cmd_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                rnd   = 9'($urandom_range(0, 511));
                tgt_l = signed'(rnd);
            end
            if ($urandom_range(0, 15) == 0) begin
                rnd   = 9'($urandom_range(0, 511));
                tgt_r = signed'(rnd);
            end
            if ($urandom_range(0, 299) == 0) estop = ~estop;
            cyc(1);
        end
        estop = 1'b0;
        cmd_if.cmd_ready = 1'b1;
        cyc(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
